// File: rtl/display_timing_pkg.sv
// display_timing_pkg: shared widths, the timing config record, reset-default timing
// and the config validity check used by the handshake.
package display_timing_pkg;
  localparam int TG_CW = 11;
  localparam int TG_AW = 19;
  typedef struct packed {
    logic [TG_CW-1:0] h_active, h_sync_s, h_sync_e, h_total;
    logic [TG_CW-1:0] v_active, v_sync_s, v_sync_e, v_total;
    logic [1:0]       h_scale, v_scale;
    logic             hs_pol, vs_pol;
    logic [TG_AW-1:0] base;
  } timing_cfg_t;
  localparam logic [TG_CW-1:0] TG_H_ACTIVE_D = 11'd400;
  localparam logic [TG_CW-1:0] TG_H_SYNC_S_D = 11'd420;
  localparam logic [TG_CW-1:0] TG_H_SYNC_E_D = 11'd484;
  localparam logic [TG_CW-1:0] TG_H_TOTAL_D  = 11'd528;
  localparam logic [TG_CW-1:0] TG_V_ACTIVE_D = 11'd600;
  localparam logic [TG_CW-1:0] TG_V_SYNC_S_D = 11'd601;
  localparam logic [TG_CW-1:0] TG_V_SYNC_E_D = 11'd605;
  localparam logic [TG_CW-1:0] TG_V_TOTAL_D  = 11'd628;
  localparam logic [1:0]       TG_H_SCALE_D  = 2'd0;
  localparam logic [1:0]       TG_V_SCALE_D  = 2'd1;
  function automatic logic axis_ok(input logic [TG_CW-1:0] act, ss, se, tot);
    return (act != '0) && (act <= ss) && (ss < se) && (se <= tot) && (tot >= TG_CW'(2));
  endfunction
  function automatic logic cfg_ok(input timing_cfg_t c);
    return axis_ok(c.h_active, c.h_sync_s, c.h_sync_e, c.h_total) &&
           axis_ok(c.v_active, c.v_sync_s, c.v_sync_e, c.v_total);
  endfunction
endpackage

// File: rtl/tg_axis_counter.sv
// tg_axis_counter: one timing axis -- wrapping counter plus active and sync region flags.
module tg_axis_counter #(
  parameter int unsigned CW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CW-1:0] total,
  input  logic [CW-1:0] active,
  input  logic [CW-1:0] sync_s,
  input  logic [CW-1:0] sync_e,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          act,
  output logic          sync
);
  assign last = cnt >= total - CW'(1);
  assign act  = cnt < active;
  assign sync = (cnt >= sync_s) && (cnt < sync_e);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + CW'(1);
endmodule

// File: rtl/display_timing_gen.sv
// display_timing_gen: programmable blanking/sync/DE generator with a scaled framebuffer
// address; new config is shadowed and only goes live at a frame boundary.
module display_timing_gen
  import display_timing_pkg::*;
#(
  parameter int unsigned      CW         = TG_CW,
  parameter int unsigned      AW         = TG_AW,
  parameter logic [CW-1:0]    H_ACTIVE_D = TG_H_ACTIVE_D,
  parameter logic [CW-1:0]    H_SYNC_S_D = TG_H_SYNC_S_D,
  parameter logic [CW-1:0]    H_SYNC_E_D = TG_H_SYNC_E_D,
  parameter logic [CW-1:0]    H_TOTAL_D  = TG_H_TOTAL_D,
  parameter logic [CW-1:0]    V_ACTIVE_D = TG_V_ACTIVE_D,
  parameter logic [CW-1:0]    V_SYNC_S_D = TG_V_SYNC_S_D,
  parameter logic [CW-1:0]    V_SYNC_E_D = TG_V_SYNC_E_D,
  parameter logic [CW-1:0]    V_TOTAL_D  = TG_V_TOTAL_D,
  parameter logic [1:0]       H_SCALE_D  = TG_H_SCALE_D,
  parameter logic [1:0]       V_SCALE_D  = TG_V_SCALE_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_sync_s,
  input  logic [CW-1:0] cfg_h_sync_e,
  input  logic [CW-1:0] cfg_h_total,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_sync_s,
  input  logic [CW-1:0] cfg_v_sync_e,
  input  logic [CW-1:0] cfg_v_total,
  input  logic [1:0]    cfg_h_scale,
  input  logic [1:0]    cfg_v_scale,
  input  logic          cfg_hs_pol,
  input  logic          cfg_vs_pol,
  input  logic [AW-1:0] cfg_base,
  output logic          cfg_pending,
  output logic          cfg_err,
  output logic          blanking,
  output logic          de,
  output logic          h_sync,
  output logic          v_sync,
  output logic [AW-1:0] addr,
  output logic          line_start,
  output logic          frame_start
);
  localparam timing_cfg_t DEF_CFG = '{
    h_active: H_ACTIVE_D, h_sync_s: H_SYNC_S_D, h_sync_e: H_SYNC_E_D, h_total: H_TOTAL_D,
    v_active: V_ACTIVE_D, v_sync_s: V_SYNC_S_D, v_sync_e: V_SYNC_E_D, v_total: V_TOTAL_D,
    h_scale: H_SCALE_D, v_scale: V_SCALE_D, hs_pol: 1'b0, vs_pol: 1'b0, base: '0};
  timing_cfg_t   live, shadow, cfg_in;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_last, v_last, h_act, v_act, h_sy, v_sy;
  logic          cfg_acc, boundary, apply, active, line_end, v_row_last;
  logic [2:0]    v_mask;
  logic [AW-1:0] line_base, stride;
  assign cfg_in = '{
    h_active: cfg_h_active, h_sync_s: cfg_h_sync_s, h_sync_e: cfg_h_sync_e, h_total: cfg_h_total,
    v_active: cfg_v_active, v_sync_s: cfg_v_sync_s, v_sync_e: cfg_v_sync_e, v_total: cfg_v_total,
    h_scale: cfg_h_scale, v_scale: cfg_v_scale, hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol, base: cfg_base};
  assign cfg_acc  = cfg_valid && cfg_ok(cfg_in);
  assign boundary = pix_en && h_last && v_last;
  assign apply    = boundary && cfg_pending;
  assign active   = h_act && v_act;
  tg_axis_counter #(.CW(CW)) u_h (
    .clk(clk), .rst_n(rst_n), .en(pix_en),
    .total(live.h_total), .active(live.h_active), .sync_s(live.h_sync_s), .sync_e(live.h_sync_e),
    .cnt(h_cnt), .last(h_last), .act(h_act), .sync(h_sy));
  tg_axis_counter #(.CW(CW)) u_v (
    .clk(clk), .rst_n(rst_n), .en(pix_en && h_last),
    .total(live.v_total), .active(live.v_active), .sync_s(live.v_sync_s), .sync_e(live.v_sync_e),
    .cnt(v_cnt), .last(v_last), .act(v_act), .sync(v_sy));
  // A source row is reused 2^v_scale times; advance only after its last replica.
  assign v_mask     = 3'b111 >> (2'd3 - live.v_scale);
  assign v_row_last = &(v_cnt[2:0] | ~v_mask);
  assign line_end   = pix_en && v_act && (h_cnt == live.h_active - CW'(1));
  assign stride     = AW'(live.h_active >> live.h_scale);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      live        <= DEF_CFG;
      shadow      <= DEF_CFG;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
      blanking    <= 1'b1;
      de          <= 1'b0;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      addr        <= '0;
      line_base   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cfg_err     <= cfg_valid && !cfg_acc;
      cfg_pending <= cfg_acc || (cfg_pending && !apply);
      if (cfg_acc) shadow <= cfg_in;
      if (apply) live <= shadow;
      if (boundary) line_base <= cfg_pending ? shadow.base : live.base;
      else if (line_end && v_row_last) line_base <= line_base + stride;
      if (pix_en) begin
        blanking    <= !active;
        de          <= active;
        h_sync      <= h_sy ~^ live.hs_pol;
        v_sync      <= v_sy ~^ live.vs_pol;
        line_start  <= h_cnt == '0;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        if (active) addr <= line_base + AW'(h_cnt >> live.h_scale);
      end
    end
endmodule
